accumulate_dump: RTL and testbench

//   Multi-channel saturating integrate-and-dump accumulator. Sums N consecutive

---
 rtl/accumulate_dump_if.sv | 39 +++
 rtl/accumulate_dump.sv | 126 ++++++++++++
 tb/tb_accumulate_dump.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/accumulate_dump_if.sv
// Sample-in / window-result-out stream bundle for accumulate_dump.
// master = producer/consumer side (drives samples and m_rdy), slave = accumulator side.
// Optional m_ovf signal exists only when ACCUMULATE_DUMP_OVF_EN is defined.
interface accumulate_dump_if #(
  parameter int W  = 16,
  parameter int A  = 24,
  parameter int CW = 1
);
  logic                s_stb;
  logic signed [W-1:0] s_dat;
  logic                s_rdy;
  logic                m_rdy;
  logic                m_stb;
  logic signed [A-1:0] m_dat;
  logic [CW-1:0]       m_chn;
`ifdef ACCUMULATE_DUMP_OVF_EN
  logic                m_ovf;

  modport master (
    output s_stb, s_dat, m_rdy,
    input  s_rdy, m_stb, m_dat, m_chn, m_ovf
  );

  modport slave (
    input  s_stb, s_dat, m_rdy,
    output s_rdy, m_stb, m_dat, m_chn, m_ovf
  );
`else
  modport master (
    output s_stb, s_dat, m_rdy,
    input  s_rdy, m_stb, m_dat, m_chn
  );

  modport slave (
    input  s_stb, s_dat, m_rdy,
    output s_rdy, m_stb, m_dat, m_chn
  );
`endif
endinterface

// File: rtl/accumulate_dump.sv
// Multi-channel saturating integrate-and-dump: N samples per channel, C channels interleaved round-robin.
// Latency: result valid 1 cycle after the last sample of a window is accepted; registered outputs.
// Backpressure: only the window-closing sample stalls, when the output holds an unconsumed result.
// Optional sticky saturation flag output m_ovf enabled by ACCUMULATE_DUMP_OVF_EN.
module accumulate_dump #(
  parameter int W = 16,
  parameter int A = 24,
  parameter int N = 4,
  parameter int C = 1
) (
  input logic              clk,
  input logic              rst_n,
  accumulate_dump_if.slave bus
);

  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [A-1:0] MAXV = {1'b0, {(A-1){1'b1}}};
  localparam logic signed [A-1:0] MINV = {1'b1, {(A-1){1'b0}}};

  logic [CW-1:0]       chn_q;
  logic [NW-1:0]       cnt_q;
  logic signed [A-1:0] acc_q [C];

  logic                dump;
  logic                fire;
  logic                first;
  logic signed [A-1:0] base;
  logic signed [A-1:0] x;
  logic [A:0]          sum;
  logic signed [A-1:0] res;
  logic                sat;

  // The last sample of a window is the only one that must wait for the output register.
  assign dump      = (cnt_q == NW'(N - 1));
  assign bus.s_rdy = ~dump | ~bus.m_stb | bus.m_rdy;
  assign fire      = bus.s_stb & bus.s_rdy;

  // A window restarts from zero rather than from the stale accumulator contents.
  assign first = (cnt_q == '0);
  assign base  = first ? '0 : acc_q[chn_q];
  assign x     = A'(bus.s_dat);
  assign sum   = {base[A-1], base} + {x[A-1], x};

  // Clamp the one-bit-wider sum back into A bits; the top two bits disagree only on overflow.
  always_comb begin
    res = sum[A-1:0];
    sat = 1'b0;
    case (sum[A:A-1])
      2'b01: begin
        res = MAXV;
        sat = 1'b1;
      end
      2'b10: begin
        res = MINV;
        sat = 1'b1;
      end
      default: ;
    endcase
  end

  // Channel pointer steps every accept; window count steps each time the channels wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chn_q <= '0;
      cnt_q <= '0;
    end else if (fire) begin
      if (chn_q == CW'(C - 1)) begin
        chn_q <= '0;
        cnt_q <= dump ? '0 : cnt_q + NW'(1);
      end else begin
        chn_q <= chn_q + CW'(1);
      end
    end
  end

  // Per-channel running sums; the dump step leaves them alone since the next window ignores them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < C; k++) acc_q[k] <= '0;
    end else if (fire && !dump) begin
      acc_q[chn_q] <= res;
    end
  end

`ifdef ACCUMULATE_DUMP_OVF_EN
  logic [C-1:0] ovf_q;
  logic         ovf_now;

  assign ovf_now = (first ? 1'b0 : ovf_q[chn_q]) | sat;

  // Sticky per-channel clamp history, restarted with each window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else if (fire && !dump) begin
      ovf_q[chn_q] <= ovf_now;
    end
  end

  // Saturation flag travels with its window result and holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_ovf <= 1'b0;
    end else if (fire && dump) begin
      bus.m_ovf <= ovf_now;
    end
  end
`endif

  // Output register: load on dump (even while releasing the old result), clear on release alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_stb <= 1'b0;
      bus.m_dat <= '0;
      bus.m_chn <= '0;
    end else if (fire && dump) begin
      bus.m_stb <= 1'b1;
      bus.m_dat <= res;
      bus.m_chn <= chn_q;
    end else if (bus.m_rdy) begin
      bus.m_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accumulate_dump.sv
// Randomized scoreboard bench for accumulate_dump (W=8, A=9, N=4, C=2).
// Reference model works on sample indices and plain integer arithmetic.
// Optional m_ovf checked when ACCUMULATE_DUMP_OVF_EN is defined.
module tb_accumulate_dump;

  localparam int W    = 8;
  localparam int A    = 9;
  localparam int N    = 4;
  localparam int C    = 2;
  localparam int CW   = 1;
  localparam int MAXV = (1 << (A - 1)) - 1;
  localparam int MINV = -(1 << (A - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  accumulate_dump_if #(.W(W), .A(A), .CW(CW)) ifc ();

  accumulate_dump #(.W(W), .A(A), .N(N), .C(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  typedef struct {
    int chn;
    int dat;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   dir_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: total accepted samples since reset, running window sums per channel.
  int   tot;
  int   run_s [C];
  bit   run_o [C];
  bit   out_v;
  bit   hold;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    tot   = 0;
    out_v = 1'b0;
    hold  = 1'b0;
    exp_q.delete();
    for (int k = 0; k < C; k++) begin
      run_s[k] = 0;
      run_o[k] = 1'b0;
    end
  endtask

  function automatic bit next_is_dump();
    return ((tot / C) % N) == (N - 1);
  endfunction

  function automatic void model_accept(int x);
    int ch;
    int pos;
    int s;
    ch  = tot % C;
    pos = (tot / C) % N;
    if (pos == 0) begin
      run_s[ch] = 0;
      run_o[ch] = 1'b0;
    end
    s = run_s[ch] + x;
    if (s > MAXV) begin
      s = MAXV;
      run_o[ch] = 1'b1;
    end else if (s < MINV) begin
      s = MINV;
      run_o[ch] = 1'b1;
    end
    run_s[ch] = s;
    if (pos == N - 1) exp_q.push_back('{ch, s, run_o[ch]});
    tot++;
  endfunction

  function automatic logic [W-1:0] gen(int mode);
    int r;
    case (mode)
      1: begin
        r = $urandom_range(0, 4);
        case (r)
          0: return W'(127);
          1: return W'(-128);
          2: return W'(100);
          3: return W'(-100);
          default: return W'($urandom_range(0, 255));
        endcase
      end
      2: return W'(int'($urandom_range(0, 15)) - 8);
      default: return W'($urandom_range(0, 255));
    endcase
  endfunction

  // Drive one cycle per iteration at negedge; decide handshakes at negedge+2.
  task automatic run_cycles(int n, int stb_pct, int rdy_pct, int mode);
    for (int i = 0; i < n; i++) begin
      bit dmp;
      bit acc;
      @(negedge clk);
      if (!hold) begin
        if (dir_q.size() > 0) begin
          ifc.s_stb = 1'b1;
          ifc.s_dat = W'(dir_q.pop_front());
        end else begin
          ifc.s_stb = ($urandom_range(0, 99) < stb_pct);
          ifc.s_dat = gen(mode);
        end
      end
      ifc.m_rdy = ($urandom_range(0, 99) < rdy_pct);
      #2;
      dmp = next_is_dump();
      check("s_rdy", int'(ifc.s_rdy), int'(!dmp || !out_v || ifc.m_rdy));
      acc = ifc.s_stb && ifc.s_rdy;
      if (acc) model_accept(int'(ifc.s_dat));
      if (acc && dmp) out_v = 1'b1;
      else if (ifc.m_rdy) out_v = 1'b0;
      hold = ifc.s_stb && !acc;
    end
  endtask

  task automatic async_reset();
    #1;
    ifc.s_stb = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_m_stb", int'(ifc.m_stb), 0);
    check("rst_m_dat", int'(ifc.m_dat), 0);
    check("rst_m_chn", int'(ifc.m_chn), 0);
`ifdef ACCUMULATE_DUMP_OVF_EN
    check("rst_m_ovf", int'(ifc.m_ovf), 0);
`endif
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Output monitor: compares the presented result against the scoreboard head every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        check("m_stb", int'(ifc.m_stb), (exp_q.size() > 0) ? 1 : 0);
        if (ifc.m_stb && exp_q.size() > 0) begin
          check("m_chn", int'(ifc.m_chn), exp_q[0].chn);
          check("m_dat", int'(ifc.m_dat), exp_q[0].dat);
`ifdef ACCUMULATE_DUMP_OVF_EN
          check("m_ovf", int'(ifc.m_ovf), int'(exp_q[0].ovf));
`endif
          if (ifc.m_rdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    ifc.s_stb = 1'b0;
    ifc.s_dat = '0;
    ifc.m_rdy = 1'b0;
    model_reset();
    #12;
    check("init_m_stb", int'(ifc.m_stb), 0);
    check("init_m_dat", int'(ifc.m_dat), 0);
    check("init_m_chn", int'(ifc.m_chn), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Interleaved basic windows: ch0 1+2+3+4, ch1 10+20+30+40.
    dir_q = '{1, 10, 2, 20, 3, 30, 4, 40};
    run_cycles(12, 0, 100, 0);

    // Clamp on both rails, then come back off the rail mid-window.
    dir_q = '{127, -128, 127, -128, 127, -128, -100, 100,
              -128, -128, -128, -128, -128, -128, -128, -128,
              100, 100, 100, 100, -50, -50, 0, 0};
    run_cycles(30, 0, 100, 0);

    // Stall the window-closing sample behind an unconsumed result, then reset mid-window.
    dir_q = '{5, 6, 5, 6, 5, 6, 5, 6, 7, 7};
    run_cycles(12, 0, 0, 0);
    async_reset();

    dir_q = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_cycles(12, 0, 100, 0);

    // Random traffic under varied handshake densities.
    run_cycles(400, 70, 70, 0);
    run_cycles(300, 90, 30, 1);
    run_cycles(200, 100, 100, 1);
    run_cycles(30, 100, 0, 2);
    run_cycles(30, 100, 100, 2);
    run_cycles(300, 60, 50, 0);

    // Partial window lost to reset, then more random traffic.
    async_reset();
    run_cycles(200, 80, 60, 1);

    // Drain: no new samples, consume everything pending.
    ifc.s_stb = 1'b0;
    hold = 1'b0;
    run_cycles(20, 0, 100, 0);
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
